// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a-b (unsigned or sign-magnitude), one full-adder slice.
// Optional SERIAL_SUB_ADDSEL_EN adds iOp to select a+b instead of a-b.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic             iSA,
  input  logic [WIDTH-1:0] iData_a,
  input  logic [WIDTH-1:0] iData_b,
`ifdef SERIAL_SUB_ADDSEL_EN
  input  logic             iOp,
`endif
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH:0]   oData,
  output logic             oData_B
);

  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t         state_q;
  logic [CW-1:0]  count_q;
  logic           carry_q;
  logic           cout_q;
  logic           sa_q;
  logic           op_q;
  logic [WIDTH:0] a_q;
  logic [WIDTH:0] nb_q;
  logic [WIDTH:0] res_q;
  logic           busy_q;
  logic           done_q;
  logic [WIDTH:0] data_q;
  logic           b_flag_q;

  logic           op_add_d;
  logic [WIDTH:0] a_ext_d;
  logic [WIDTH:0] b_ext_d;
  logic           sum_d;
  logic           carry_d;
  logic           neg_d;
  logic [WIDTH:0] abs_d;
  logic [WIDTH:0] data_d;
  logic           b_flag_d;

  // Widen to WIDTH+1-bit two's complement; SM negative zero maps to 0 naturally.
  function automatic logic [WIDTH:0] to_ext(input logic [WIDTH-1:0] v, input logic sm);
    logic [WIDTH:0] mag;
    if (!sm) begin
      to_ext = {1'b0, v};
    end else begin
      mag    = {2'b00, v[WIDTH-2:0]};
      to_ext = v[WIDTH-1] ? (~mag + 1'b1) : mag;
    end
  endfunction

  always_comb begin
`ifdef SERIAL_SUB_ADDSEL_EN
    op_add_d = iOp;
`else
    op_add_d = 1'b0;
`endif
    a_ext_d = to_ext(iData_a, iSA);
    b_ext_d = to_ext(iData_b, iSA);
  end

  // The single full-adder slice.
  always_comb begin
    sum_d   = a_q[0] ^ nb_q[0] ^ carry_q;
    carry_d = (a_q[0] & nb_q[0]) | (carry_q & (a_q[0] ^ nb_q[0]));
  end

  // Result formatting used in FIX; res_q holds the complete raw difference.
  always_comb begin
    neg_d    = res_q[WIDTH];
    abs_d    = neg_d ? (~res_q + 1'b1) : res_q;
    data_d   = res_q;
    b_flag_d = op_q ? cout_q : ~cout_q;
    if (sa_q) begin
      data_d   = {neg_d, abs_d[WIDTH-1:0]};
      b_flag_d = (abs_d > (WIDTH+1)'((1 << (WIDTH-1)) - 1));
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      sa_q     <= 1'b0;
      op_q     <= 1'b0;
      a_q      <= '0;
      nb_q     <= '0;
      res_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      data_q   <= '0;
      b_flag_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (iStart) begin
            sa_q    <= iSA;
            op_q    <= op_add_d;
            a_q     <= a_ext_d;
            nb_q    <= op_add_d ? b_ext_d : ~b_ext_d;
            carry_q <= ~op_add_d;
            cout_q  <= 1'b0;
            count_q <= '0;
            res_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          a_q     <= a_q >> 1;
          nb_q    <= nb_q >> 1;
          res_q   <= {sum_d, res_q[WIDTH:1]};
          carry_q <= carry_d;
          // Carry out of bit WIDTH-1 gives the unsigned borrow/carry flag.
          if (count_q == CW'(WIDTH - 1)) begin
            cout_q <= carry_d;
          end
          count_q <= count_q + 1'b1;
          if (count_q == CW'(WIDTH)) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          data_q   <= data_d;
          b_flag_q <= b_flag_d;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign oBusy   = busy_q;
  assign oDone   = done_q;
  assign oData   = data_q;
  assign oData_B = b_flag_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor (default build).
module tb_serial_subtractor;

  logic       iClk = 1'b0;
  logic       iRst;
  logic       iStart;
  logic       iSA;
  logic [7:0] iData_a;
  logic [7:0] iData_b;
  logic       oBusy;
  logic       oDone;
  logic [8:0] oData;
  logic       oData_B;

  serial_subtractor #(.WIDTH(8)) dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iSA(iSA),
    .iData_a(iData_a), .iData_b(iData_b),
    .oBusy(oBusy), .oDone(oDone), .oData(oData), .oData_B(oData_B)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic [8:0] data;
    logic       b;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic exp_t model(logic [7:0] a, logic [7:0] b, logic sa);
    exp_t e;
    int va, vb, d, m;
    if (!sa) begin
      d      = int'(a) - int'(b);
      e.data = 9'(d);
      e.b    = (a < b);
    end else begin
      va     = a[7] ? -int'(a[6:0]) : int'(a[6:0]);
      vb     = b[7] ? -int'(b[6:0]) : int'(b[6:0]);
      d      = va - vb;
      m      = (d < 0) ? -d : d;
      e.data = {(d < 0), 8'(m)};
      e.b    = (m > 127);
    end
    return e;
  endfunction

  // Drives one request for a single cycle and records its expected result.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic sa);
    iData_a = a;
    iData_b = b;
    iSA     = sa;
    iStart  = 1'b1;
    sb_q.push_back(model(a, b, sa));
    @(posedge iClk); #1;
    iStart = 1'b0;
  endtask

  task automatic wait_done(output int cycles, output bit ok);
    cycles = 0;
    while (!oDone && cycles < 40) begin
      @(posedge iClk); #1;
      cycles++;
    end
    ok = oDone;
  endtask

  task automatic test_reset;
    iRst = 1'b1; iStart = 1'b0; iSA = 1'b0; iData_a = '0; iData_b = '0;
    repeat (3) @(posedge iClk);
    #1;
    n_checks++;
    if ({oBusy, oDone, oData, oData_B} !== 12'h000)
      $display("FAIL reset_outputs got busy=%b done=%b data=%h b=%b want all 0", oBusy, oDone, oData, oData_B);
    else n_pass++;
    iRst = 1'b0;
    @(posedge iClk); #1;
  endtask

  task automatic test_ops(input string name, input logic sa, input logic [7:0] ta[], input logic [7:0] tb[]);
    int cyc; bit ok; exp_t e;
    foreach (ta[i]) begin
      start_op(ta[i], tb[i], sa);
      n_checks++;
      if (oBusy !== 1'b1) $display("FAIL %s_busy[%0d] got %b want 1", name, i, oBusy);
      else n_pass++;
      wait_done(cyc, ok);
      e = sb_q.pop_front();
      n_checks++;
      if (!ok || cyc != 10) $display("FAIL %s_latency[%0d] got %0d done=%b want 10", name, i, cyc, ok);
      else n_pass++;
      n_checks++;
      if (oData !== e.data || oData_B !== e.b || oBusy !== 1'b0)
        $display("FAIL %s_result[%0d] a=%h b=%h got data=%h B=%b busy=%b want data=%h B=%b busy=0",
                 name, i, ta[i], tb[i], oData, oData_B, oBusy, e.data, e.b);
      else n_pass++;
      @(posedge iClk); #1;
      n_checks++;
      if (oDone !== 1'b0 || oData !== e.data) $display("FAIL %s_hold[%0d] done=%b data=%h want done=0 data=%h", name, i, oDone, oData, e.data);
      else n_pass++;
    end
  endtask

  task automatic test_unsigned;
    logic [7:0] ta[] = '{8'd200, 8'd5, 8'd0, 8'd255, 8'd0, 8'd128, 8'd77, 8'd0};
    logic [7:0] tb[] = '{8'd55, 8'd10, 8'd0, 8'd0, 8'd255, 8'd127, 8'd0, 8'd0};
    ta[6] = 8'($urandom); tb[6] = 8'($urandom);
    ta[7] = 8'($urandom); tb[7] = 8'($urandom);
    test_ops("unsigned", 1'b0, ta, tb);
  endtask

  task automatic test_sign_mag;
    logic [7:0] ta[] = '{8'h05, 8'hFF, 8'h80, 8'h7F, 8'h80, 8'h83, 8'h00, 8'h00};
    logic [7:0] tb[] = '{8'h8A, 8'h7F, 8'h00, 8'hFF, 8'h80, 8'h03, 8'h00, 8'h00};
    ta[6] = 8'($urandom); tb[6] = 8'($urandom);
    ta[7] = 8'($urandom); tb[7] = 8'($urandom);
    test_ops("signmag", 1'b1, ta, tb);
  endtask

  task automatic test_start_ignored;
    int cyc; bit ok; exp_t e; int extra;
    start_op(8'd100, 8'd30, 1'b0);
    repeat (2) @(posedge iClk);
    #1;
    iData_a = 8'd1; iData_b = 8'd250; iSA = 1'b1; iStart = 1'b1;
    @(posedge iClk); #1;
    iStart = 1'b0;
    wait_done(cyc, ok);
    e = sb_q.pop_front();
    n_checks++;
    if (!ok || cyc != 7 || oData !== e.data || oData_B !== e.b)
      $display("FAIL ignored_start got done=%b cyc=%0d data=%h B=%b want cyc=7 data=%h B=%b", ok, cyc, oData, oData_B, e.data, e.b);
    else n_pass++;
    extra = 0;
    repeat (14) begin
      @(posedge iClk); #1;
      if (oDone || oBusy) extra++;
    end
    n_checks++;
    if (extra != 0) $display("FAIL ignored_no_second_op got %0d active cycles want 0", extra);
    else n_pass++;
  endtask

  task automatic test_reset_abort;
    int dones;
    start_op(8'd9, 8'd3, 1'b0);
    void'(sb_q.pop_back());
    repeat (4) @(posedge iClk);
    #1;
    iRst = 1'b1;
    @(posedge iClk); #1;
    iRst = 1'b0;
    dones = 0;
    repeat (14) begin
      if (oDone) dones++;
      @(posedge iClk); #1;
    end
    n_checks++;
    if (dones != 0 || {oBusy, oData, oData_B} !== 11'h000)
      $display("FAIL reset_abort got dones=%0d busy=%b data=%h B=%b want none and 0", dones, oBusy, oData, oData_B);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int cyc; bit ok; exp_t e;
    start_op(8'd60, 8'd61, 1'b0);
    wait_done(cyc, ok);
    start_op(8'h85, 8'h02, 1'b1);
    n_checks++;
    if (oBusy !== 1'b1) $display("FAIL b2b_accept busy got %b want 1", oBusy);
    else n_pass++;
    e = sb_q.pop_front();
    n_checks++;
    if (!ok || oData !== e.data || oData_B !== e.b)
      $display("FAIL b2b_first got done=%b data=%h B=%b want data=%h B=%b", ok, oData, oData_B, e.data, e.b);
    else n_pass++;
    wait_done(cyc, ok);
    e = sb_q.pop_front();
    n_checks++;
    if (!ok || cyc != 10 || oData !== e.data || oData_B !== e.b)
      $display("FAIL b2b_second got done=%b cyc=%0d data=%h B=%b want cyc=10 data=%h B=%b", ok, cyc, oData, oData_B, e.data, e.b);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_sign_mag();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL scoreboard_empty got %0d entries want 0", sb_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
